// File: rtl/ic148_irq_encoder.sv
// ic148_irq_encoder: registered 8-to-3 priority encoder with 74148-style pins.
// Synchronizes active-low request lines, latches their falling edges as
// pending requests and presents the highest pending index under valid/ack.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   EI_n   - enable input, active-low, asynchronous (synchronized here)
//   I_n    - request lines, active-low, I_n[7] highest priority, asynchronous
//   ack    - consumer accepts the presented code
//   valid  - code is presented
//   code   - binary index of granted request
//   A_n    - inverted code while valid, else all ones
//   GS_n   - group select, active-low (~valid)
//   EO_n   - enable output, low only when enabled, idle and nothing pending
module ic148_irq_encoder (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       EI_n,
   input  logic [7:0] I_n,
   input  logic       ack,
   output logic       valid,
   output logic [2:0] code,
   output logic [2:0] A_n,
   output logic       GS_n,
   output logic       EO_n
);

   localparam int unsigned N_LINES = 8;
   localparam int unsigned CODE_W  = 3;

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t              state;
   logic [N_LINES-1:0]  s1_i, s2_i, s3_i;
   logic                s1_ei, s2_ei;
   logic [N_LINES-1:0]  pending;
   logic [N_LINES-1:0]  set_mask;
   logic [N_LINES-1:0]  clr_mask;
   logic [CODE_W-1:0]   high_idx;

   // Two-stage synchronizers; s3 keeps the previous synchronized request level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_i  <= '1;
         s2_i  <= '1;
         s3_i  <= '1;
         s1_ei <= 1'b1;
         s2_ei <= 1'b1;
      end else begin
         s1_i  <= I_n;
         s2_i  <= s1_i;
         s3_i  <= s2_i;
         s1_ei <= EI_n;
         s2_ei <= s1_ei;
      end
   end

   // Falling edge of a synchronized line raises exactly one request
   assign set_mask = s3_i & ~s2_i;

   // Clear the granted bit on the accepting edge
   always_comb begin
      clr_mask = '0;
      if (state == PRESENT && ack)
         clr_mask[code] = 1'b1;
   end

   // Highest set index wins; ascending scan lets later (higher) bits override
   always_comb begin
      high_idx = '0;
      for (int unsigned k = 0; k < N_LINES; k++)
         if (pending[k])
            high_idx = CODE_W'(k);
   end

   // Pending requests; a set on the same edge as a clear takes precedence
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pending <= '0;
      else
         pending <= (pending & ~clr_mask) | set_mask;
   end

   // Grant/handshake FSM with registered 74148 outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         valid <= 1'b0;
         code  <= '0;
         A_n   <= '1;
         GS_n  <= 1'b1;
         EO_n  <= 1'b1;
      end else begin
         EO_n <= ~(~s2_ei && (pending == '0) && ~valid);
         case (state)
            IDLE: begin
               if (~s2_ei && (pending != '0)) begin
                  state <= PRESENT;
                  valid <= 1'b1;
                  code  <= high_idx;
                  A_n   <= ~high_idx;
                  GS_n  <= 1'b0;
               end
            end
            PRESENT: begin
               if (ack) begin
                  state <= IDLE;
                  valid <= 1'b0;
                  A_n   <= '1;
                  GS_n  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ic148_irq_encoder.sv
// Bench for ic148_irq_encoder: expected codes are queued when requests are
// driven and popped when a handshake (valid && ack) completes.
module tb_ic148_irq_encoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       EI_n;
   logic [7:0] I_n;
   logic       ack;
   logic       valid;
   logic [2:0] code;
   logic [2:0] A_n;
   logic       GS_n;
   logic       EO_n;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned hs_cnt = 0;
   int unsigned exp_q[$];

   ic148_irq_encoder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .EI_n  (EI_n),
      .I_n   (I_n),
      .ack   (ack),
      .valid (valid),
      .code  (code),
      .A_n   (A_n),
      .GS_n  (GS_n),
      .EO_n  (EO_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, landing 1 time unit after the last one
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scoreboard: a handshake completes on the next edge when valid && ack now
   always @(negedge clk) begin
      if (rst_n && valid && ack) begin
         hs_cnt++;
         if (exp_q.size() == 0)
            chk("sb_unexpected_grant", 32'(code), 32'hFFFF_FFFF);
         else
            chk("sb_code", 32'(code), 32'(exp_q.pop_front()));
         chk("sb_an", 32'(A_n), 32'(3'(~code)));
         chk("sb_gs", 32'(GS_n), 32'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned hs0;
      bit found;

      rst_n = 1'b0; EI_n = 1'b0; I_n = 8'hFF; ack = 1'b0;
      step(2);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_code",  32'(code),  32'd0);
      chk("rst_an",    32'(A_n),   32'd7);
      chk("rst_gs",    32'(GS_n),  32'd1);
      chk("rst_eo",    32'(EO_n),  32'd1);
      rst_n = 1'b1;
      step(4);
      chk("idle_eo", 32'(EO_n), 32'd0);

      // Single request on line 5, no ack
      I_n = 8'hDF; exp_q.push_back(5);
      step(1);                      // after edge 0
      I_n = 8'hFF;
      step(2);                      // after edge 2
      chk("single_lat_valid", 32'(valid), 32'd0);
      step(1);                      // after edge 3
      chk("single_valid", 32'(valid), 32'd1);
      chk("single_code",  32'(code),  32'd5);
      chk("single_an",    32'(A_n),   32'b010);
      chk("single_gs",    32'(GS_n),  32'd0);
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("single_hold_valid", 32'(valid), 32'd1);
         chk("single_hold_code",  32'(code),  32'd5);
      end
      ack = 1'b1;
      step(1);
      chk("single_ack_valid", 32'(valid), 32'd0);
      chk("single_ack_gs",    32'(GS_n),  32'd1);
      ack = 1'b0;
      step(3);

      // Priority: lines 7, 6, 2 together, ack held
      I_n = 8'h3B; ack = 1'b1;
      exp_q.push_back(7); exp_q.push_back(6); exp_q.push_back(2);
      step(1);
      I_n = 8'hFF;
      step(2);                      // after edge 2
      for (int i = 0; i < 6; i++) begin
         step(1);                   // edges 3..8
         chk("prio_valid", 32'(valid), (i % 2 == 0) ? 32'd1 : 32'd0);
      end
      ack = 1'b0;
      step(2);
      chk("prio_eo_drained", 32'(EO_n), 32'd0);
      chk("prio_q_empty", 32'(exp_q.size()), 32'd0);

      // Held line 3 grants once per falling edge
      hs0 = hs_cnt;
      I_n = 8'hF7; ack = 1'b1; exp_q.push_back(3);
      step(20);
      chk("held_once", hs_cnt - hs0, 32'd1);
      I_n = 8'hFF;
      step(3);
      I_n = 8'hF7; exp_q.push_back(3);
      step(8);
      I_n = 8'hFF;
      step(4);
      chk("held_twice", hs_cnt - hs0, 32'd2);
      ack = 1'b0;
      step(2);

      // Enable gating
      EI_n = 1'b1;
      step(4);
      I_n = 8'hFD; exp_q.push_back(1);
      step(1);
      I_n = 8'hFF;
      step(6);
      chk("gate_valid", 32'(valid), 32'd0);
      chk("gate_eo",    32'(EO_n),  32'd1);
      EI_n = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 4 && !found; i++) begin
         step(1);
         if (valid) found = 1'b1;
      end
      chk("gate_grant_in_4", 32'(found), 32'd1);
      chk("gate_code", 32'(code), 32'd1);
      ack = 1'b1;
      step(2);
      ack = 1'b0;
      step(2);

      // Re-trigger line 4 so its set lands on the clearing ack edge
      I_n = 8'hEF; ack = 1'b1;
      exp_q.push_back(4); exp_q.push_back(4);
      step(1);                      // after e0
      I_n = 8'hFF;
      step(1);                      // after e1
      I_n = 8'hEF;
      step(1);                      // after e2
      I_n = 8'hFF;
      step(1);                      // after e3
      chk("sim_first_valid", 32'(valid), 32'd1);
      step(1);                      // after e4: ack clear and re-set together
      chk("sim_gap_valid", 32'(valid), 32'd0);
      step(1);                      // after e5
      chk("sim_second_valid", 32'(valid), 32'd1);
      chk("sim_second_code",  32'(code),  32'd4);
      step(1);
      chk("sim_done_valid", 32'(valid), 32'd0);
      step(3);
      chk("sim_no_third", 32'(valid), 32'd0);
      ack = 1'b0;
      step(2);

      // Reset mid-PRESENT with pending 7 and 0
      I_n = 8'h7E;
      step(1);
      I_n = 8'hFF;
      step(3);                      // after edge 3
      chk("rst2_pre_valid", 32'(valid), 32'd1);
      chk("rst2_pre_code",  32'(code),  32'd7);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst2_valid", 32'(valid), 32'd0);
      chk("rst2_code",  32'(code),  32'd0);
      chk("rst2_an",    32'(A_n),   32'd7);
      chk("rst2_gs",    32'(GS_n),  32'd1);
      chk("rst2_eo",    32'(EO_n),  32'd1);
      step(2);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step(1);
         chk("rst2_no_replay", 32'(valid), 32'd0);
      end

      chk("final_q_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
